// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM state encoding, default widths and the requester index constants.
package mem_arb_pkg;

    localparam int ADDR_W_DEFAULT = 13;
    localparam int DATA_W_DEFAULT = 16;

    // Requester indices; port 0 is instruction fetch, port 1 is data.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick with a sticky override that lets port 1 keep ownership.
// Purely combinational; the caller decides when the pick is consumed.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock,
    output logic       grant
);

    always_comb begin
        grant = PORT0;
        // A locked port 1 keeps the memory as long as it is still asking for it.
        if (lock && req[PORT1]) begin
            grant = PORT1;
        end else if (req[PORT0] && req[PORT1]) begin
            grant = ~last;
        end else if (req[PORT1]) begin
            grant = PORT1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single-port memory: IDLE -> ACCESS -> RESP,
// one access per three cycles, registered read data per port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p0_ack,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              lock_q, lock_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              pick;

    rr_arbiter2 u_rr (
        .req   ({p1_req, p0_req}),
        .last  (last_q),
        .lock  (lock_q),
        .grant (pick)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        last_d     = last_q;
        lock_d     = lock_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    grant_d = pick;
                    we_d    = (pick == PORT1) ? p1_we    : p0_we;
                    addr_d  = (pick == PORT1) ? p1_addr  : p0_addr;
                    wdata_d = (pick == PORT1) ? p1_wdata : p0_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (grant_q == PORT1) begin
                        p1_rdata_d = mem_rdata;
                    end else begin
                        p0_rdata_d = mem_rdata;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                // Lock is judged at the ack: only a locked port-1 completion carries over.
                last_d  = grant_q;
                lock_d  = (grant_q == PORT1) && p1_lock;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= PORT0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_q     <= PORT1;
            lock_q     <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            last_q     <= last_d;
            lock_q     <= lock_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    // Strobes decode straight from the state flop, so an asynchronous reset kills them at once.
    assign mem_read  = (state_q == ACCESS) && !we_q;
    assign mem_write = (state_q == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign p0_ack    = (state_q == RESP) && (grant_q == PORT0);
    assign p1_ack    = (state_q == RESP) && (grant_q == PORT1);
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

    a_ack_exclusive: assert property (@(posedge clk) disable iff (rst) !(p0_ack && p1_ack));
    a_strobe_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          env_init = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p0_ack, p1_ack, mem_read, mem_write;
    logic [DW-1:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem_env [0:8191];

    always #5 clk = ~clk;

    // Environment memory: word i starts as i+100, writes commit on the rising edge.
    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 8192; i++) mem_env[i] <= 16'(i + 100);
        end else if (mem_write) begin
            mem_env[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_env[mem_addr];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock),
        .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic clear_inputs();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_lock = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 0;
        p0_req = 1; p0_addr = 13'd5;
        #2 rst = 1;
        #1;
        n_cmp++; if ({p0_ack, p1_ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks: got %b expected 00", {p0_ack, p1_ack}); end
        n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b expected 00", {mem_read, mem_write}); end
        n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        n_cmp++; if (mem_wdata !== '0) begin n_err++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        n_cmp++; if (p0_rdata !== '0) begin n_err++; $display("FAIL reset_p0_rdata: got %h expected 0", p0_rdata); end
        n_cmp++; if (p1_rdata !== '0) begin n_err++; $display("FAIL reset_p1_rdata: got %h expected 0", p1_rdata); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL reset_hold_read: got %b expected 0", mem_read); end
        @(negedge clk);
        rst = 0;
        clear_inputs();
        n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected IDLE", dut.state_q); end
        $display("reset: done");
    endtask

    task automatic test_single_read();
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_addr = 13'd5;
        @(posedge clk); #1;
        n_cmp++; if ({mem_read, mem_write, p0_ack} !== 3'b100) begin n_err++; $display("FAIL single_access: got rd/wr/ack %b expected 100", {mem_read, mem_write, p0_ack}); end
        n_cmp++; if (mem_addr !== 13'd5) begin n_err++; $display("FAIL single_addr: got %h expected 5", mem_addr); end
        @(posedge clk); #1;
        n_cmp++; if ({p0_ack, p1_ack, mem_read} !== 3'b100) begin n_err++; $display("FAIL single_ack: got ack0/ack1/rd %b expected 100", {p0_ack, p1_ack, mem_read}); end
        n_cmp++; if (p0_rdata !== 16'h0069) begin n_err++; $display("FAIL single_rdata: got %h expected 0069", p0_rdata); end
        p0_req = 0;
        @(posedge clk); #1;
        n_cmp++; if (p0_ack !== 1'b0) begin n_err++; $display("FAIL single_ack_pulse: got %b expected 0", p0_ack); end
        $display("txn single_read port 0 addr 5 rdata %h", p0_rdata);
    endtask

    task automatic test_write_read();
        int acks = 0, wr = 0, cyc = 0, t1 = 0, t2 = 0;
        @(negedge clk);
        p1_req = 1; p1_we = 1; p1_addr = 13'd100; p1_wdata = 16'hBEEF;
        while (acks < 2 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_write) wr++;
            if (p1_ack) begin
                acks++;
                if (acks == 1) begin p1_we = 0; t1 = cyc; end
                else begin p1_req = 0; t2 = cyc; end
            end
        end
        p1_req = 0;
        @(posedge clk); #1;
        n_cmp++; if (acks != 2) begin n_err++; $display("FAIL wr_rd_acks: got %0d expected 2", acks); end
        n_cmp++; if (wr != 1) begin n_err++; $display("FAIL wr_rd_write_cycles: got %0d expected 1", wr); end
        n_cmp++; if (t1 != 2 || t2 != 5) begin n_err++; $display("FAIL wr_rd_timing: got %0d,%0d expected 2,5", t1, t2); end
        n_cmp++; if (p1_rdata !== 16'hBEEF) begin n_err++; $display("FAIL wr_rd_rdata: got %h expected BEEF", p1_rdata); end
        n_cmp++; if (mem_env[100] !== 16'hBEEF) begin n_err++; $display("FAIL wr_rd_memory: got %h expected BEEF", mem_env[100]); end
        $display("txn write_read port 1 addr 100 rdata %h", p1_rdata);
    endtask

    task automatic test_contention(input bit with_lock);
        int n = 0, cyc = 0, n1 = 0;
        logic drop_lock = 0;
        logic port_q [4];
        int t_q [4];
        logic exp_port [4];
        do_reset();
        p0_req = 1; p0_addr = 13'd10;
        p1_req = 1; p1_addr = with_lock ? 13'd40 : 13'd20; p1_lock = with_lock;
        for (int k = 0; k < 4; k++) exp_port[k] = k[0];
        if (with_lock) begin exp_port[2] = 1; exp_port[3] = 0; end
        while (n < 4 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (drop_lock) begin p1_lock = 0; drop_lock = 0; end
            n_cmp++; if (p0_ack && p1_ack) begin n_err++; $display("FAIL contention_both_acks: got 11 expected one-hot"); end
            if (p0_ack || p1_ack) begin
                port_q[n] = p1_ack; t_q[n] = cyc; n++;
                $display("txn contention lock=%0b grant %0d port %0d cycle %0d", with_lock, n, p1_ack, cyc);
            end
            if (p1_ack) begin n1++; if (n1 == 1 && with_lock) drop_lock = 1; end
        end
        p0_req = 0; p1_req = 0; p1_lock = 0;
        @(posedge clk); #1;
        n_cmp++; if (n != 4) begin n_err++; $display("FAIL contention_ack_count: got %0d expected 4", n); end
        for (int k = 0; k < n; k++) begin
            n_cmp++; if (port_q[k] !== exp_port[k]) begin n_err++; $display("FAIL contention_order[%0d]: got port %0d expected %0d", k, port_q[k], exp_port[k]); end
            n_cmp++; if (t_q[k] != 2 + 3 * k) begin n_err++; $display("FAIL contention_time[%0d]: got %0d expected %0d", k, t_q[k], 2 + 3 * k); end
        end
        n_cmp++; if (p0_rdata !== 16'd110) begin n_err++; $display("FAIL contention_p0_rdata: got %h expected 006E", p0_rdata); end
        n_cmp++; if (p1_rdata !== (with_lock ? 16'd140 : 16'd120)) begin n_err++; $display("FAIL contention_p1_rdata: got %h", p1_rdata); end
    endtask

    task automatic test_reset_mid_access();
        int acks = 0;
        @(negedge clk);
        p1_req = 1; p1_we = 1; p1_addr = 13'd7; p1_wdata = 16'h1234;
        @(posedge clk); #1;
        n_cmp++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL midrst_access: got mem_write %b expected 1", mem_write); end
        #1 rst = 1;
        #1;
        n_cmp++; if ({mem_write, mem_read} !== 2'b00) begin n_err++; $display("FAIL midrst_async_strobe: got %b expected 00", {mem_write, mem_read}); end
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (p0_ack || p1_ack) acks++;
        end
        n_cmp++; if (acks != 0) begin n_err++; $display("FAIL midrst_no_ack: got %0d acks expected 0", acks); end
        n_cmp++; if (mem_env[7] !== 16'h006B) begin n_err++; $display("FAIL midrst_memory: got %h expected 006B", mem_env[7]); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL midrst_state: got %0d expected IDLE", dut.state_q); end
        n_cmp++; if (p1_rdata !== '0) begin n_err++; $display("FAIL midrst_rdata_clear: got %h expected 0", p1_rdata); end
        $display("txn reset_mid_access port 1 addr 7 aborted");
    endtask

    task automatic test_dropped_req();
        int busy = 0;
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_addr = 13'd50;
        #2 p0_req = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (mem_read || mem_write || p0_ack || p1_ack) busy++;
        end
        n_cmp++; if (busy != 0) begin n_err++; $display("FAIL drop_pulse_ignored: got %0d active cycles expected 0", busy); end
        @(negedge clk);
        p0_req = 1; p0_addr = 13'd60;
        @(posedge clk); #1;
        n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL drop_granted: got mem_read %b expected 1", mem_read); end
        p0_req = 0; p0_addr = 13'h1FFF;
        #1;
        n_cmp++; if (mem_addr !== 13'd60) begin n_err++; $display("FAIL drop_latched_addr: got %h expected 3C", mem_addr); end
        @(posedge clk); #1;
        n_cmp++; if (p0_ack !== 1'b1) begin n_err++; $display("FAIL drop_still_acks: got %b expected 1", p0_ack); end
        n_cmp++; if (p0_rdata !== 16'h00A0) begin n_err++; $display("FAIL drop_rdata: got %h expected 00A0", p0_rdata); end
        @(posedge clk); #1;
        $display("txn dropped_req port 0 addr 60 rdata %h", p0_rdata);
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_mem [16];
        logic          pend [2];
        logic          we_m [2];
        logic [AW-1:0] addr_m [2];
        logic [DW-1:0] wd_m [2];
        logic [DW-1:0] exp_rd [2];
        logic          lock_m, m_last, m_lock;
        int            w, idx;
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'(300 + i);
        m_last = 1; m_lock = 0; lock_m = 0;
        for (int p = 0; p < 2; p++) begin pend[p] = 0; exp_rd[p] = '0; we_m[p] = 0; addr_m[p] = '0; wd_m[p] = '0; end
        for (int s = 0; s < 150; s++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 99) < 55) begin
                    pend[p]   = 1;
                    we_m[p]   = 1'($urandom_range(0, 1));
                    addr_m[p] = 13'(200 + $urandom_range(0, 15));
                    wd_m[p]   = 16'($urandom);
                    if (p == 1) lock_m = ($urandom_range(0, 2) == 0);
                end
            end
            p0_req = pend[0]; p0_we = we_m[0]; p0_addr = addr_m[0]; p0_wdata = wd_m[0];
            p1_req = pend[1]; p1_we = we_m[1]; p1_addr = addr_m[1]; p1_wdata = wd_m[1];
            p1_lock = lock_m;
            if (!pend[0] && !pend[1]) begin
                @(posedge clk); #1;
                n_cmp++; if ({mem_read, mem_write, p0_ack, p1_ack} !== 4'b0) begin n_err++; $display("FAIL rand_idle[%0d]: got %b expected 0000", s, {mem_read, mem_write, p0_ack, p1_ack}); end
                continue;
            end
            // Locked port 1 keeps ownership; otherwise a lone requester wins, and on a tie the one not served last.
            if (m_lock && pend[1]) w = 1;
            else if (pend[0] && pend[1]) w = m_last ? 0 : 1;
            else w = pend[1] ? 1 : 0;
            @(posedge clk); #1;
            n_cmp++;
            if ({mem_read, mem_write, mem_addr, mem_wdata} !== {!we_m[w], we_m[w], addr_m[w], wd_m[w]}) begin
                n_err++;
                $display("FAIL rand_access[%0d]: got rd%b wr%b a%h d%h expected rd%b wr%b a%h d%h", s, mem_read, mem_write, mem_addr, mem_wdata, !we_m[w], we_m[w], addr_m[w], wd_m[w]);
            end
            if ($urandom_range(0, 3) == 0) begin
                if (w == 0) begin p0_req = 0; p0_addr = 13'($urandom); end
                else begin p1_req = 0; p1_addr = 13'($urandom); end
            end
            @(posedge clk); #1;
            idx = int'(addr_m[w]) - 200;
            if (we_m[w]) ref_mem[idx] = wd_m[w];
            else exp_rd[w] = ref_mem[idx];
            n_cmp++; if ({p1_ack, p0_ack} !== ((w == 1) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rand_ack[%0d]: got %b expected port %0d", s, {p1_ack, p0_ack}, w); end
            n_cmp++; if ({p0_rdata, p1_rdata} !== {exp_rd[0], exp_rd[1]}) begin n_err++; $display("FAIL rand_rdata[%0d]: got %h/%h expected %h/%h", s, p0_rdata, p1_rdata, exp_rd[0], exp_rd[1]); end
            $display("txn rand %0d port %0d we %0b addr %0d wdata %h lock %0b", s, w, we_m[w], addr_m[w], wd_m[w], (w == 1) && lock_m);
            m_lock = (w == 1) && lock_m;
            m_last = w[0];
            pend[w] = 0;
            if (w == 0) p0_req = 0; else p1_req = 0;
            @(posedge clk); #1;
            n_cmp++; if ({p0_ack, p1_ack} !== 2'b00) begin n_err++; $display("FAIL rand_ack_pulse[%0d]: got %b expected 00", s, {p0_ack, p1_ack}); end
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1 env_init = 0;
        test_reset();
        test_single_read();
        test_write_read();
        test_contention(1'b0);
        test_contention(1'b1);
        test_reset_mid_access();
        test_dropped_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 The block SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports p0_req in 1, p0_we in 1, p0_addr in ADDR_W, p0_wdata in DATA_W: instruction-fetch requester.
REQ-006 The block SHALL have ports p1_req in 1, p1_we in 1, p1_addr in ADDR_W, p1_wdata in DATA_W, p1_lock in 1: data requester, where p1_lock requests back-to-back ownership.
REQ-007 The block SHALL have ports p0_ack, p1_ack out 1 (one-cycle completion pulse) and p0_rdata, p1_rdata out DATA_W (registered read data).
REQ-008 The block SHALL have ports mem_read out 1, mem_write out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W: single-port memory with combinational read and write on rising edge.

Function
REQ-009 The FSM SHALL have states IDLE, ACCESS and RESP; it SHALL occupy exactly one cycle in each of ACCESS and RESP.
REQ-010 In IDLE with any pN_req high, the block SHALL select a winner, latch its we/addr/wdata and go to ACCESS; with no request, it SHALL stay in IDLE.
REQ-011 Arbitration SHALL be round-robin: when both requests are high, the port not granted last SHALL win; after reset, port 0 SHALL have priority.
REQ-012 Override: if the last grant went to port 1 with p1_lock high at its ack, and p1_req is high in IDLE, port 1 SHALL win regardless of p0_req.
REQ-013 In ACCESS, mem_addr/mem_wdata SHALL equal the latched values, and mem_read = !we, mem_write = we; outside ACCESS, mem_read and mem_write SHALL be 0.
REQ-014 At the end of ACCESS, for a read, the block SHALL capture mem_rdata into the winner's pN_rdata; the other port's rdata SHALL hold its value.
REQ-015 In RESP, the block SHALL assert the winner's pN_ack for exactly one cycle, then return to IDLE.
REQ-016 Latency: with req sampled high in IDLE at edge N, ack SHALL be high in cycle N+2 with rdata valid; throughput SHALL be one access per 3 cycles.
REQ-017 Requesters SHALL hold req/we/addr/wdata stable until their ack; the block SHALL use only latched values after the IDLE edge.
REQ-018 A req dropped before grant SHALL be ignored; a req dropped after grant SHALL still complete and ack.
REQ-019 p0_ack and p1_ack SHALL never be high simultaneously; mem_read and mem_write SHALL never be high simultaneously.
REQ-020 Address/data SHALL pass through unmodified; there is no wrap or arithmetic on addresses.

Reset
REQ-021 Asserting rst SHALL force IDLE immediately, with mem_read = mem_write = 0, acks = 0, pN_rdata = 0, mem_addr/mem_wdata = 0, last-grant = port 1 (so port 0 wins next), and the lock flag = 0.
REQ-022 If rst is asserted during ACCESS, no write SHALL be committed, because mem_write drops asynchronously, and no ack SHALL be issued for the aborted access.

Structure
REQ-023 The package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), ADDR_W/DATA_W defaults, and the port index constants.
REQ-024 The sub-module rr_arbiter2 SHALL contain the two-way round-robin pick (inputs req[1:0], last, lock; output grant index); all other logic SHALL be in mem_arbiter.

Verification
REQ-025 Single read: memory[5]=16'h0069, p0 reads addr 5 -> mem_read high in cycle N+1, p0_ack in N+2, p0_rdata=16'h0069.
REQ-026 Write then read: p1 writes 16'hBEEF to addr 100, then reads addr 100 -> second ack gives p1_rdata=16'hBEEF, and mem_write is high for exactly one cycle.
REQ-027 Contention: p0 and p1 request continuously from reset -> grant order is 0,1,0,1, with acks every 3 cycles.
REQ-028 Lock: p1 requests with p1_lock=1 while p0_req is held -> p1 gets two consecutive grants; after it acks with lock=0, p0 is granted next.
REQ-029 Reset mid-access: p1 writes 16'h1234 to addr 7 (old 16'h006B), with rst pulsed during ACCESS -> no ack, memory[7] stays 16'h006B, and the FSM is in IDLE.
REQ-030 Dropped request: p0_req high for 0 cycles at an IDLE edge, pulsed between edges -> no grant; p0_req dropped during ACCESS -> p0_ack still occurs.
